// File: rtl/sa_autosa_sdp_autosahls_sa_syncn2data_pkg.sv
// sa_autosa_sdp_autosahls_sa_syncn2data_pkg: legal configuration limits and buffer address width helper
package sa_autosa_sdp_autosahls_sa_syncn2data_pkg;
    localparam int NCH_MIN   = 2;
    localparam int NCH_MAX   = 8;
    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 64;

    function automatic int aw_of(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit cfg_ok(input int nch, input int depth);
        return nch >= NCH_MIN && nch <= NCH_MAX && depth >= DEPTH_MIN && depth <= DEPTH_MAX &&
               (depth & (depth - 1)) == 0;
    endfunction
endpackage

// File: rtl/sa_autosa_sdp_autosahls_sa_sync_fifo.sv
// sa_autosa_sdp_autosahls_sa_sync_fifo: per-channel buffer with flush, occupancy and registered head
module sa_autosa_sdp_autosahls_sa_sync_fifo
    import sa_autosa_sdp_autosahls_sa_syncn2data_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = aw_of(DEPTH)
) (
    input  logic                  autosa_core_clk,
    input  logic                  autosa_core_rstn,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  empty,
    output logic [AW:0]           lvl,
    output logic [DATA_WIDTH-1:0] head
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;

    assign full  = lvl == (AW+1)'(DEPTH);
    assign empty = lvl == '0;
    assign head  = mem[rp];

    // pointers are exactly AW bits wide, so increments wrap modulo DEPTH
    always_ff @(posedge autosa_core_clk) begin
        if (!autosa_core_rstn || flush) begin
            wp  <= '0;
            rp  <= '0;
            lvl <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            lvl <= lvl + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge autosa_core_clk)
        if (push) mem[wp] <= din;
endmodule

// File: rtl/sa_autosa_sdp_autosahls_sa_syncn2data.sv
// sa_autosa_sdp_autosahls_sa_syncn2data: aligns NCH independent valid/ready streams into one beat
module sa_autosa_sdp_autosahls_sa_syncn2data
    import sa_autosa_sdp_autosahls_sa_syncn2data_pkg::*;
#(
    parameter int NCH = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = aw_of(DEPTH)
) (
    input  logic                      autosa_core_clk,
    input  logic                      autosa_core_rstn,
    input  logic [NCH-1:0]            chn_en,
    input  logic [NCH-1:0]            chn_in_pvld,
    output logic [NCH-1:0]            chn_in_prdy,
    input  logic [NCH*DATA_WIDTH-1:0] data_in,
    output logic                      chn_out_pvld,
    input  logic                      chn_out_prdy,
    output logic [NCH*DATA_WIDTH-1:0] data_out,
    output logic [NCH*(AW+1)-1:0]     fifo_lvl
);
    logic [NCH-1:0] full, empty, push, pop;
    logic [DATA_WIDTH-1:0] head [NCH];

    if (!cfg_ok(NCH, DEPTH)) begin : g_bad_cfg
        $error("illegal NCH/DEPTH configuration");
    end

    assign chn_out_pvld = |chn_en && &(~empty | ~chn_en);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign chn_in_prdy[i] = chn_en[i] ? autosa_core_rstn && !full[i] : 1'b1;
        assign push[i] = chn_in_pvld[i] && chn_en[i] && chn_in_prdy[i];
        assign pop[i]  = chn_out_pvld && chn_out_prdy && chn_en[i];
        // empty gate keeps unreset storage off the output after reset/flush
        assign data_out[i*DATA_WIDTH +: DATA_WIDTH] = chn_en[i] && !empty[i] ? head[i] : '0;

        sa_autosa_sdp_autosahls_sa_sync_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH(DEPTH)
        ) u_fifo (
            .autosa_core_clk (autosa_core_clk),
            .autosa_core_rstn(autosa_core_rstn),
            .push            (push[i]),
            .pop             (pop[i]),
            .flush           (!chn_en[i]),
            .din             (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .full            (full[i]),
            .empty           (empty[i]),
            .lvl             (fifo_lvl[i*(AW+1) +: AW+1]),
            .head            (head[i])
        );
    end
endmodule

// File: tb/tb_sa_autosa_sdp_autosahls_sa_syncn2data.sv
// tb_sa_autosa_sdp_autosahls_sa_syncn2data: directed scenarios for the two-channel, depth-4 aligner
module tb_sa_autosa_sdp_autosahls_sa_syncn2data;
    localparam logic [31:0] A = 32'hA000_0000, B = 32'hB000_0000, C0 = 32'hC0C0_0000, H0 = 32'h1111_0000;
    logic clk = 1'b0, rstn, out_pvld, out_prdy;
    logic [1:0] en, in_pvld, in_prdy;
    logic [63:0] din, dout;
    logic [5:0] lvl;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    sa_autosa_sdp_autosahls_sa_syncn2data dut (
        .autosa_core_clk (clk),
        .autosa_core_rstn(rstn),
        .chn_en          (en),
        .chn_in_pvld     (in_pvld),
        .chn_in_prdy     (in_prdy),
        .data_in         (din),
        .chn_out_pvld    (out_pvld),
        .chn_out_prdy    (out_prdy),
        .data_out        (dout),
        .fifo_lvl        (lvl)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rstn = 1'b0; en = 2'b11; in_pvld = 2'b00; out_prdy = 1'b1; din = '0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; en = 2'b11; in_pvld = 2'b00; out_prdy = 1'b1; din = '0;
        tick();
        checks++; if (in_prdy !== 2'b00) begin errors++; $display("FAIL rst_prdy got %b exp 00", in_prdy); end
        checks++; if (lvl !== 6'd0) begin errors++; $display("FAIL rst_lvl got %h exp 0", lvl); end
        checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL rst_pvld got %b exp 0", out_pvld); end
        checks++; if (dout !== 64'd0) begin errors++; $display("FAIL rst_dout got %h exp 0", dout); end
        rstn = 1'b1;
        #1;
        checks++; if (in_prdy !== 2'b11) begin errors++; $display("FAIL rst_rel_prdy got %b exp 11", in_prdy); end
    endtask

    task automatic test_align;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            in_pvld = {c >= 2 && c <= 5, c <= 3};
            din = {32'(B + c - 2), 32'(A + c)};
            #1;
            checks++; if (out_pvld !== (c >= 3 && c <= 6)) begin errors++; $display("FAIL align_pvld c=%0d got %b", c, out_pvld); end
            if (c >= 3 && c <= 6) begin
                checks++;
                if (dout !== {32'(B + c - 3), 32'(A + c - 3)}) begin errors++; $display("FAIL align_data c=%0d got %h exp %h", c, dout, {32'(B + c - 3), 32'(A + c - 3)}); end
            end
            tick();
        end
        in_pvld = 2'b00;
        checks++; if (lvl !== 6'd0) begin errors++; $display("FAIL align_lvl got %h exp 0", lvl); end
    endtask

    task automatic test_full;
        do_reset();
        in_pvld = 2'b01;
        din = {32'h0, 32'h5a5a_0000};
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (in_prdy[0] !== (c < 4)) begin errors++; $display("FAIL full_prdy c=%0d got %b exp %b", c, in_prdy[0], c < 4); end
            checks++; if (lvl[2:0] !== 3'(c < 4 ? c : 4)) begin errors++; $display("FAIL full_lvl c=%0d got %0d", c, lvl[2:0]); end
            checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL full_pvld c=%0d got %b exp 0", c, out_pvld); end
            tick();
        end
        in_pvld = 2'b00;
    endtask

    task automatic test_disabled;
        do_reset();
        en = 2'b10;
        for (int c = 0; c < 4; c++) begin
            in_pvld = {c <= 1, 1'b1};
            din = {32'(B + 32'h100 + c), 32'hdead_beef};
            #1;
            checks++; if (in_prdy[0] !== 1'b1) begin errors++; $display("FAIL dis_prdy c=%0d got %b exp 1", c, in_prdy[0]); end
            checks++; if (lvl[2:0] !== 3'd0) begin errors++; $display("FAIL dis_lvl c=%0d got %0d exp 0", c, lvl[2:0]); end
            checks++; if (out_pvld !== (c == 1 || c == 2)) begin errors++; $display("FAIL dis_pvld c=%0d got %b", c, out_pvld); end
            if (c == 1 || c == 2) begin
                checks++;
                if (dout !== {32'(B + 32'h100 + c - 1), 32'h0}) begin errors++; $display("FAIL dis_data c=%0d got %h", c, dout); end
            end
            tick();
        end
        en = 2'b11; in_pvld = 2'b00;
    endtask

    task automatic test_stall;
        do_reset();
        out_prdy = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_pvld = c <= 1 ? 2'b11 : 2'b00;
            din = {32'(B + c), 32'(A + c)};
            out_prdy = c == 5;
            #1;
            if (c >= 2) begin
                checks++; if (out_pvld !== 1'b1) begin errors++; $display("FAIL stall_pvld c=%0d got %b exp 1", c, out_pvld); end
                checks++;
                if (dout !== (c <= 5 ? {B, A} : {32'(B + 1), 32'(A + 1)})) begin errors++; $display("FAIL stall_data c=%0d got %h", c, dout); end
                checks++;
                if (lvl !== (c <= 5 ? {3'd2, 3'd2} : {3'd1, 3'd1})) begin errors++; $display("FAIL stall_lvl c=%0d got %h", c, lvl); end
            end
            tick();
        end
        out_prdy = 1'b1;
    endtask

    task automatic test_flush;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            in_pvld = 2'b01;
            din = {32'h0, 32'(32'h6000_0000 + c)};
            tick();
        end
        in_pvld = 2'b00;
        #1;
        checks++; if (lvl[2:0] !== 3'd3) begin errors++; $display("FAIL flush_pre_lvl got %0d exp 3", lvl[2:0]); end
        en = 2'b10;
        #1;
        checks++; if (in_prdy[0] !== 1'b1) begin errors++; $display("FAIL flush_prdy got %b exp 1", in_prdy[0]); end
        tick();
        checks++; if (lvl[2:0] !== 3'd0) begin errors++; $display("FAIL flush_lvl got %0d exp 0", lvl[2:0]); end
        en = 2'b11; in_pvld = 2'b11; din = {H0, C0};
        tick();
        in_pvld = 2'b00;
        #1;
        checks++; if (out_pvld !== 1'b1) begin errors++; $display("FAIL flush_pvld got %b exp 1", out_pvld); end
        checks++; if (dout !== {H0, C0}) begin errors++; $display("FAIL flush_data got %h exp %h", dout, {H0, C0}); end
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        out_prdy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_pvld = 2'b11;
            din = {32'(B + c), 32'(A + c)};
            tick();
        end
        in_pvld = 2'b00;
        #1;
        checks++; if (lvl !== {3'd2, 3'd2}) begin errors++; $display("FAIL mid_pre_lvl got %h", lvl); end
        checks++; if (out_pvld !== 1'b1) begin errors++; $display("FAIL mid_pre_pvld got %b exp 1", out_pvld); end
        rstn = 1'b0;
        #1;
        checks++; if (in_prdy !== 2'b00) begin errors++; $display("FAIL mid_prdy got %b exp 00", in_prdy); end
        tick();
        checks++; if (lvl !== 6'd0) begin errors++; $display("FAIL mid_lvl got %h exp 0", lvl); end
        checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL mid_pvld got %b exp 0", out_pvld); end
        checks++; if (dout !== 64'd0) begin errors++; $display("FAIL mid_dout got %h exp 0", dout); end
        rstn = 1'b1; out_prdy = 1'b1;
        tick();
        checks++; if (out_pvld !== 1'b0 || lvl !== 6'd0) begin errors++; $display("FAIL mid_post got pvld %b lvl %h exp 0 0", out_pvld, lvl); end
    endtask

    initial begin
        test_reset();
        test_align();
        test_full();
        test_disabled();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sa_autosa_sdp_autosahls_sa_syncn2data.md
SA_AUTOSA_SDP_AUTOSAHLS_SA_SYNCN2DATA -- requirements
Module: SA_AUTOSA_SDP_AUTOSAHLS_sa_syncn2data

Interface
REQ-001 SHALL have parameter NCH, default 2, number of input channels (legal 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, per-channel payload width.
REQ-003 SHALL have parameter DEPTH, default 4, per-channel buffer entries (power of 2, legal 2..64); AW = log2(DEPTH).
REQ-004 SHALL have port autosa_core_clk  input  1  sole clock; all logic is rising-edge.
REQ-005 SHALL have port autosa_core_rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port chn_en  input  NCH  per-channel enable.
REQ-007 SHALL have port chn_in_pvld  input  NCH  per-channel input valid.
REQ-008 SHALL have port chn_in_prdy  output  NCH  per-channel input ready.
REQ-009 SHALL have port data_in  input  NCH*DATA_WIDTH  channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port chn_out_pvld  output  1  aligned output valid.
REQ-011 SHALL have port chn_out_prdy  input  1  aligned output ready.
REQ-012 SHALL have port data_out  output  NCH*DATA_WIDTH  aligned payload, same packing as data_in.
REQ-013 SHALL have port fifo_lvl  output  NCH*(AW+1)  per-channel occupancy, 0..DEPTH.

Function
REQ-014 Each channel SHALL own a DEPTH-entry FIFO; push on chn_in_pvld[i] & chn_in_prdy[i] & chn_en[i].
REQ-015 Enabled channel: chn_in_prdy[i] = ~full[i]; no same-cycle pop-to-push bypass (full FIFO stays not-ready even if popping).
REQ-016 Disabled channel: chn_in_prdy[i] = 1, input discarded, no push.
REQ-017 chn_out_pvld SHALL be 1 iff at least one chn_en bit is 1 and every enabled FIFO is non-empty; 0 when chn_en is all zero.
REQ-018 Output handshake (chn_out_pvld & chn_out_prdy) SHALL pop exactly one entry from every enabled FIFO in the same cycle, none from disabled.
REQ-019 data_out slice i SHALL be head of FIFO i when chn_en[i]=1, else all zeros; driven from registered storage, no combinational path from data_in.
REQ-020 Latency: entry pushed in cycle N SHALL be visible at output no earlier than cycle N+1; full throughput of one aligned beat per cycle when all FIFOs hold >=1 entry and chn_out_prdy=1.
REQ-021 Simultaneous push and pop on the same FIFO SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-022 chn_en[i] sampled 1->0 SHALL flush FIFO i (pointers and occupancy to 0) on the next clock edge; entries are lost.
REQ-023 chn_out_pvld SHALL not depend on chn_out_prdy; once asserted it SHALL stay asserted with stable data_out until handshake, unless chn_en changes.
REQ-024 fifo_lvl slice i SHALL equal current registered occupancy of FIFO i.

Reset
REQ-025 On autosa_core_rstn=0 at a clock edge all FIFO pointers and occupancies SHALL clear; fifo_lvl=0, chn_out_pvld=0, data_out=0 from the following cycle.
REQ-026 chn_in_prdy SHALL be 0 for enabled channels while autosa_core_rstn=0; reset asserted mid-transfer discards all buffered data.
REQ-027 FIFO storage arrays SHALL not be reset.

Structure
REQ-028 A shared package SHALL hold legal-range limits for NCH/DEPTH and the AW derivation function.
REQ-029 Per-channel buffer SHALL be a sub-module SA_AUTOSA_SDP_AUTOSAHLS_sa_sync_fifo (push, pop, flush, full, empty, lvl, head data), instantiated NCH times by generate.

Verification
REQ-030 NCH=2, both enabled, ch0 sends A0..A3 over cycles 0-3, ch1 sends B0..B3 over cycles 2-5, prdy=1 -> four beats {A0,B0}..{A3,B3}, first beat at cycle 3.
REQ-031 DEPTH=4, ch0 fed continuously, ch1 idle -> chn_in_prdy[0] drops after 4 pushes, fifo_lvl[0]=4, chn_out_pvld=0.
REQ-032 chn_en=2'b10 -> chn_in_prdy[0]=1 always, data_out slice 0 = 0, output follows ch1 alone.
REQ-033 chn_out_prdy held 0 for 3 cycles with pvld=1 -> data_out stable, no pop, then single pop on release.
REQ-034 ch0 holds 3 entries, chn_en[0] dropped -> fifo_lvl[0]=0 next cycle; re-enable, push C0 -> C0 is first output.
REQ-035 Reset asserted with both FIFOs at lvl 2 -> next cycle fifo_lvl=0, chn_out_pvld=0, data_out=0.
